// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and helpers
package uart_pkg;
  typedef enum logic [1:0] {WL5, WL6, WL7, WL8} word_len_e;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_e;
  function automatic logic tx_parity(logic [7:0] d, word_len_e wl, logic even, logic force_par);
    logic [7:0] m;
    m = 8'hff >> (3'd3 - {1'b0, wl});
    return force_par ? ~even : (^(d & m) ^ ~even);
  endfunction
endpackage

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: circular-buffer FIFO with level counter and synchronous flush
module uart_sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [LW-1:0]    level
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == LW'(DEPTH);
  assign empty = level == '0;
  assign do_push = push & ~full & ~flush;
  assign do_pop = pop & ~empty;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/uart_tx_flow.sv
// uart_tx_flow: TX FIFO plus frame serializer with RTS/CTS flow control and level interrupt
module uart_tx_flow import uart_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int OSR = 16,
  localparam int LW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          div_clk_en,
  input  logic          wr_valid,
  output logic          wr_ready,
  input  logic [7:0]    wr_data,
  input  logic          cts_n,
  input  logic [1:0]    cfg_word_len,
  input  logic          cfg_stop_bit,
  input  logic          cfg_parity_en,
  input  logic          cfg_even_parity,
  input  logic          cfg_force_parity,
  input  logic          cfg_set_break,
  input  logic          cfg_afc_en,
  input  logic          cfg_tx_reset,
  input  logic [LW-1:0] cfg_tx_trig,
  output logic [LW-1:0] fifo_level,
  output logic          tx_idle,
  output logic          int_tx_trig,
  output logic          tx
);
  localparam int CW = $clog2(OSR);
  tx_state_e state, state_d;
  word_len_e wl;
  logic [1:0] cts_sync;
  logic [7:0] rdata, dat;
  logic [CW-1:0] cnt;
  logic [2:0] bit_cnt, bit_d;
  logic cts_ok, empty, full, pop, bit_end, last_data, last_stop, par_en, par_val, stop2, tx_d;
  uart_sync_fifo #(.DEPTH(DEPTH), .WIDTH(8)) u_fifo (
    .clk, .rst_n, .flush(cfg_tx_reset), .push(wr_valid), .wdata(wr_data),
    .full, .pop, .rdata, .empty, .level(fifo_level)
  );
  assign wr_ready = ~full;
  assign cts_ok = ~cfg_afc_en | ~cts_sync[1];
  assign tx_idle = empty & (state == IDLE);
  assign int_tx_trig = fifo_level <= cfg_tx_trig;
  assign bit_end = div_clk_en & (cnt == CW'(OSR - 1));
  assign last_data = bit_cnt == {1'b1, wl};
  assign last_stop = bit_cnt[0] == stop2;
  // bit_cnt indexes data bits in DATA and stop bits in STOP
  always_comb begin
    state_d = state;
    bit_d = bit_cnt;
    pop = 1'b0;
    case (state)
      IDLE: pop = ~empty & cts_ok;
      START: if (bit_end) begin
        state_d = DATA;
        bit_d = '0;
      end
      DATA: if (bit_end) begin
        state_d = last_data ? (par_en ? PARITY : STOP) : DATA;
        bit_d = last_data ? '0 : bit_cnt + 3'd1;
      end
      PARITY: if (bit_end) state_d = STOP;
      STOP: if (bit_end) begin
        pop = last_stop & ~empty & cts_ok;
        state_d = last_stop ? IDLE : STOP;
        bit_d = bit_cnt + 3'd1;
      end
      default: state_d = IDLE;
    endcase
    if (pop) begin
      state_d = START;
      bit_d = '0;
    end
    tx_d = cfg_set_break ? 1'b0 : state_d == START ? 1'b0 : state_d == DATA ? dat[bit_d] :
           state_d == PARITY ? par_val : 1'b1;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cts_sync <= 2'b11;
      tx <= 1'b1;
      cnt <= '0;
      bit_cnt <= '0;
      dat <= '0;
      wl <= WL5;
      par_en <= 1'b0;
      par_val <= 1'b0;
      stop2 <= 1'b0;
    end else begin
      cts_sync <= {cts_sync[0], cts_n};
      tx <= tx_d;
      cnt <= (pop || state == IDLE || bit_end) ? '0 : cnt + CW'(div_clk_en);
      bit_cnt <= bit_d;
      if (pop) begin
        dat <= rdata;
        wl <= word_len_e'(cfg_word_len);
        par_en <= cfg_parity_en;
        par_val <= tx_parity(rdata, word_len_e'(cfg_word_len), cfg_even_parity, cfg_force_parity);
        stop2 <= cfg_stop_bit;
      end
    end
endmodule

// File: tb/tb_uart_tx_flow.sv
// tb_uart_tx_flow: directed and randomized frame checks against a bit-list reference model
module tb_uart_tx_flow;
  localparam int DEPTH = 4, OSR = 16, LW = $clog2(DEPTH + 1);
  logic clk = 0, rst_n = 1, div_clk_en = 0, wr_valid = 0, cts_n = 0;
  logic cfg_stop_bit = 0, cfg_parity_en = 0, cfg_even_parity = 0, cfg_force_parity = 0;
  logic cfg_set_break = 0, cfg_afc_en = 0, cfg_tx_reset = 0;
  logic [7:0] wr_data = 0;
  logic [1:0] cfg_word_len = 3;
  logic [LW-1:0] cfg_tx_trig = 1;
  logic wr_ready, tx_idle, int_tx_trig, tx;
  logic [LW-1:0] fifo_level;
  int checks = 0, errors = 0;
  logic [7:0] exp_q[$];
  bit exp_bits[$];

  uart_tx_flow #(.DEPTH(DEPTH), .OSR(OSR)) dut (
    .clk(clk), .rst_n(rst_n), .div_clk_en(div_clk_en), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .cts_n(cts_n), .cfg_word_len(cfg_word_len), .cfg_stop_bit(cfg_stop_bit),
    .cfg_parity_en(cfg_parity_en), .cfg_even_parity(cfg_even_parity), .cfg_force_parity(cfg_force_parity),
    .cfg_set_break(cfg_set_break), .cfg_afc_en(cfg_afc_en), .cfg_tx_reset(cfg_tx_reset),
    .cfg_tx_trig(cfg_tx_trig), .fifo_level(fifo_level), .tx_idle(tx_idle), .int_tx_trig(int_tx_trig), .tx(tx)
  );

  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    #1 div_clk_en = ~div_clk_en;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level of every bit of one frame, from the current configuration
  function automatic void build_frame(input logic [7:0] d);
    int w, ones;
    w = 5 + int'(cfg_word_len);
    ones = 0;
    exp_bits.delete();
    exp_bits.push_back(1'b0);
    for (int i = 0; i < w; i++) begin
      exp_bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (cfg_parity_en) exp_bits.push_back(cfg_force_parity ? !cfg_even_parity : ((ones % 2 == 1) == cfg_even_parity));
    exp_bits.push_back(1'b1);
    if (cfg_stop_bit) exp_bits.push_back(1'b1);
  endfunction

  task automatic push(input logic [7:0] d, input bit acc);
    @(posedge clk);
    #1 wr_valid = 1;
    wr_data = d;
    @(negedge clk);
    chk("wr_ready", wr_ready, acc);
    if (acc) exp_q.push_back(d);
    @(posedge clk);
    #1 wr_valid = 0;
  endtask

  // Checks n consecutive frames tick by tick, starting at the first low level of tx
  task automatic watch(input int n);
    int t;
    t = 0;
    while (tx !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    chk("start_seen", t < 2000, 1);
    for (int f = 0; f < n; f++) begin
      build_frame(exp_q.pop_front());
      chk("level_at_pop", fifo_level, exp_q.size());
      chk("trig_at_pop", int_tx_trig, exp_q.size() <= int'(cfg_tx_trig));
      foreach (exp_bits[b]) for (int k = 0; k < OSR; k++) begin
        t = 0;
        while (div_clk_en !== 1'b1 && t < 8) begin
          @(negedge clk);
          t++;
        end
        chk($sformatf("f%0d_bit%0d_tick%0d", f, b, k), tx, exp_bits[b]);
        @(negedge clk);
      end
    end
  endtask

  task automatic block_cts();
    @(posedge clk);
    #1 cfg_afc_en = 1;
    cts_n = 1;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    int t, lows, n;
    #2 rst_n = 0;
    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_level", fifo_level, 0);
    chk("rst_tx_idle", tx_idle, 1);
    chk("rst_trig", int_tx_trig, 1);
    @(posedge clk);
    #1 rst_n = 1;
    // 8N1 0xA5
    push(8'hA5, 1);
    @(negedge clk);
    chk("a5_level", fifo_level, 1);
    chk("a5_tx_before_pop", tx, 1);
    watch(1);
    chk("a5_idle", tx_idle, 1);
    // 7 bits, odd parity, 2 stop bits, 0x03
    cfg_word_len = 2;
    cfg_parity_en = 1;
    cfg_even_parity = 0;
    cfg_stop_bit = 1;
    push(8'h03, 1);
    watch(1);
    chk("o72_idle", tx_idle, 1);
    // Fill while CTS blocks, then release for back-to-back frames
    cfg_word_len = 3;
    cfg_parity_en = 0;
    cfg_stop_bit = 0;
    cfg_tx_trig = 1;
    block_cts();
    for (int i = 0; i < 5; i++) push(8'($urandom), i < 4);
    @(negedge clk);
    chk("full_level", fifo_level, 4);
    chk("full_trig", int_tx_trig, 0);
    chk("full_idle", tx_idle, 0);
    repeat (40) @(negedge clk);
    chk("blocked_tx", tx, 1);
    @(posedge clk);
    #1 cts_n = 0;
    watch(4);
    chk("b2b_idle", tx_idle, 1);
    chk("b2b_trig", int_tx_trig, 1);
    // CTS raised mid-frame
    block_cts();
    push(8'h5A, 1);
    push(8'hC3, 1);
    @(posedge clk);
    #1 cts_n = 0;
    fork
      watch(1);
      begin
        repeat (60) @(posedge clk);
        #1 cts_n = 1;
      end
    join
    repeat (100) @(negedge clk);
    chk("held_tx", tx, 1);
    chk("held_level", fifo_level, 1);
    chk("held_idle", tx_idle, 0);
    @(posedge clk);
    #1 cts_n = 0;
    watch(1);
    chk("held_done_idle", tx_idle, 1);
    // Push and pop in the same cycle at level 2, then flush mid-frame
    block_cts();
    push(8'h11, 1);
    push(8'h22, 1);
    @(posedge clk);
    #1 cts_n = 0;
    @(posedge clk);
    @(posedge clk);
    #1 wr_valid = 1;
    wr_data = 8'h33;
    exp_q.push_back(8'h33);
    @(negedge clk);
    chk("sync_latency_tx", tx, 1);
    @(posedge clk);
    #1 wr_valid = 0;
    @(negedge clk);
    chk("pushpop_level", fifo_level, 2);
    chk("pushpop_tx", tx, 0);
    fork
      watch(1);
      begin
        repeat (50) @(posedge clk);
        #1 cfg_tx_reset = 1;
        @(posedge clk);
        #1 cfg_tx_reset = 0;
        exp_q.delete();
        @(negedge clk);
        chk("flush_level", fifo_level, 0);
        chk("flush_not_idle", tx_idle, 0);
      end
    join
    chk("flush_idle", tx_idle, 1);
    repeat (50) @(negedge clk);
    chk("flush_tx", tx, 1);
    // Randomized configurations, 1..3 frames each
    for (int r = 0; r < 6; r++) begin
      cfg_word_len = 2'($urandom_range(0, 3));
      cfg_parity_en = 1'($urandom_range(0, 1));
      cfg_even_parity = 1'($urandom_range(0, 1));
      cfg_force_parity = 1'($urandom_range(0, 1));
      cfg_stop_bit = 1'($urandom_range(0, 1));
      cfg_tx_trig = LW'($urandom_range(0, 4));
      n = $urandom_range(1, 3);
      block_cts();
      for (int i = 0; i < n; i++) push(8'($urandom), 1);
      @(posedge clk);
      #1 cts_n = 0;
      watch(n);
      chk("rand_idle", tx_idle, 1);
    end
    // Break hides a consumed frame
    cfg_afc_en = 0;
    cfg_force_parity = 0;
    cfg_word_len = 3;
    cfg_parity_en = 0;
    cfg_stop_bit = 0;
    cfg_set_break = 1;
    push(8'hFF, 1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    chk("break_tx", tx, 0);
    t = 0;
    while (tx_idle !== 1'b1 && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("break_frame_len", t >= 300 && t < 400, 1);
    chk("break_tx_end", tx, 0);
    @(posedge clk);
    #1 cfg_set_break = 0;
    @(negedge clk);
    @(negedge clk);
    chk("break_release_tx", tx, 1);
    // Reset in the middle of a data bit
    block_cts();
    push(8'h00, 1);
    push(8'h00, 1);
    @(posedge clk);
    #1 cts_n = 0;
    t = 0;
    while (tx !== 1'b0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    repeat (50) @(negedge clk);
    chk("pre_reset_tx", tx, 0);
    rst_n = 0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_wr_ready", wr_ready, 1);
    chk("mid_rst_level", fifo_level, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1;
    lows = 0;
    repeat (400) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    chk("post_rst_quiet", lows, 0);
    chk("post_rst_idle", tx_idle, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
